// File: rtl/expr_eval_stream.sv
// expr_eval_stream: streaming ASCII NUM (OP NUM)* '=' recogniser/evaluator; ports clk, reset (async high), in_valid, in[7:0] -> legal, done, ok, result[WIDTH-1:0]
module expr_eval_stream #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 4,
  parameter bit ENABLE_MUL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             legal,
  output logic             done,
  output logic             ok,
  output logic [WIDTH-1:0] result
);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  typedef enum logic [1:0] {EXPECT, NUM, ERROR} state_t;
  state_t r_state, w_state;
  logic [WIDTH-1:0] r_sum, r_term, r_num, r_result, w_sum, w_term, w_num, w_result;
  logic [WIDTH-1:0] w_d, w_prod, w_total;
  logic [DW-1:0] r_dcnt, w_dcnt;
  logic r_done, r_ok, w_done, w_ok;
  logic w_digit, w_plus, w_minus, w_mul, w_eq;
  assign w_digit = in >= 8'h30 && in <= 8'h39;
  assign w_plus  = in == 8'h2B;
  assign w_minus = in == 8'h2D;
  assign w_mul   = in == 8'h2A && ENABLE_MUL;
  assign w_eq    = in == 8'h3D;
  assign w_d     = WIDTH'(in - 8'h30);
  assign w_prod  = r_term * r_num;
  assign w_total = r_sum + w_prod;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state  <= EXPECT;
      r_sum    <= '0;
      r_term   <= WIDTH'(1);
      r_num    <= '0;
      r_dcnt   <= '0;
      r_done   <= 1'b0;
      r_ok     <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state;
      r_sum    <= w_sum;
      r_term   <= w_term;
      r_num    <= w_num;
      r_dcnt   <= w_dcnt;
      r_done   <= w_done;
      r_ok     <= w_ok;
      r_result <= w_result;
    end
  always_comb begin
    w_state  = r_state;
    w_sum    = r_sum;
    w_term   = r_term;
    w_num    = r_num;
    w_dcnt   = r_dcnt;
    w_done   = 1'b0;
    w_ok     = r_ok;
    w_result = r_result;
    if (in_valid && w_eq) begin
      // every '=' ends the expression and re-arms for the next one
      w_state = EXPECT;
      w_done  = 1'b1;
      w_ok    = r_state == NUM;
      w_result = r_state == NUM ? w_total : r_result;
      w_sum   = '0;
      w_term  = WIDTH'(1);
      w_num   = '0;
      w_dcnt  = '0;
    end else if (in_valid)
      case (r_state)
        EXPECT: begin
          w_state = w_digit ? NUM : ERROR;
          w_num   = w_d;
          w_dcnt  = DW'(1);
        end
        NUM:
          if (w_digit) begin
            w_state = r_dcnt == DW'(MAX_DIGITS) ? ERROR : NUM;
            w_num   = r_num * WIDTH'(10) + w_d;
            w_dcnt  = r_dcnt + DW'(1);
          end else if (w_plus || w_minus || w_mul) begin
            // '*' folds the number into the running product; '+'/'-' close the term
            w_state = EXPECT;
            w_sum   = w_mul ? r_sum : w_total;
            w_term  = w_mul ? w_prod : (w_minus ? '1 : WIDTH'(1));
            w_num   = '0;
            w_dcnt  = '0;
          end else
            w_state = ERROR;
        default: w_state = ERROR;
      endcase
  end
  assign legal  = r_state == NUM;
  assign done   = r_done;
  assign ok     = r_ok;
  assign result = r_result;
endmodule
